// File: rtl/ram_2p_rr_arbiter.sv
// Round-robin arbiter sharing one port of the dual-port byte-enable RAM among NREQ requesters.
// Define RAM_2P_RR_ARBITER_WRACK_EN to also return a response strobe for accepted writes.
module ram_2p_rr_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned BYTES  = 4,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ-1:0]           req_we_i,
    input  logic [NREQ*AWIDTH-1:0]    req_addr_i,
    input  logic [NREQ*BYTES-1:0]     req_be_i,
    input  logic [NREQ*BYTES*8-1:0]   req_wdata_i,
    output logic [NREQ-1:0]           rsp_valid_o,
    output logic [BYTES*8-1:0]        rsp_rdata_o,
    output logic [AWIDTH-1:0]         ram_address_o,
    output logic                      ram_ce_o,
    output logic                      ram_we_o,
    output logic [BYTES-1:0]          ram_be_o,
    output logic [BYTES*8-1:0]        ram_d_o,
    input  logic [BYTES*8-1:0]        ram_q_i
);

    localparam int unsigned DW = BYTES * 8;
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic          rsp_pend_q, rsp_pend_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
`ifdef RAM_2P_RR_ARBITER_WRACK_EN
    logic          rsp_wr_q, rsp_wr_d;
`endif

    // First valid requester at or after the pointer wins; nothing is granted during reset.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(ptr_q) + k) % NREQ);
            if (!win_vld && req_valid_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_vld = win_vld & rst_n;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_vld) begin
            ptr_d = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_comb begin
        req_ready_o   = '0;
        ram_ce_o      = 1'b0;
        ram_we_o      = 1'b0;
        ram_address_o = '0;
        ram_be_o      = '0;
        ram_d_o       = '0;
        if (win_vld) begin
            req_ready_o   = NREQ'(1) << win_idx;
            ram_ce_o      = 1'b1;
            ram_we_o      = req_we_i[win_idx];
            ram_address_o = req_addr_i[win_idx*AWIDTH +: AWIDTH];
            ram_be_o      = req_be_i[win_idx*BYTES +: BYTES];
            ram_d_o       = req_wdata_i[win_idx*DW +: DW];
        end
    end

    // Response bookkeeping: which requester sees the RAM output next cycle.
    always_comb begin
`ifdef RAM_2P_RR_ARBITER_WRACK_EN
        rsp_pend_d = win_vld;
        rsp_wr_d   = win_vld & req_we_i[win_idx];
`else
        rsp_pend_d = win_vld & ~req_we_i[win_idx];
`endif
        rsp_id_d   = rsp_pend_d ? win_idx : rsp_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= '0;
`ifdef RAM_2P_RR_ARBITER_WRACK_EN
            rsp_wr_q   <= 1'b0;
`endif
        end else begin
            ptr_q      <= ptr_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
`ifdef RAM_2P_RR_ARBITER_WRACK_EN
            rsp_wr_q   <= rsp_wr_d;
`endif
        end
    end

    always_comb begin
        rsp_valid_o = rsp_pend_q ? (NREQ'(1) << rsp_id_q) : '0;
`ifdef RAM_2P_RR_ARBITER_WRACK_EN
        rsp_rdata_o = (rsp_pend_q && !rsp_wr_q) ? ram_q_i : '0;
`else
        rsp_rdata_o = rsp_pend_q ? ram_q_i : '0;
`endif
    end

endmodule

// File: tb/tb_ram_2p_rr_arbiter.sv
// Bench for ram_2p_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_ram_2p_rr_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned BYTES = 4;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
`ifdef RAM_2P_RR_ARBITER_WRACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*BYTES-1:0]  req_be;
    logic [NREQ*DW-1:0]     req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [DW-1:0]          rsp_rdata;
    logic [AW-1:0]          ram_address;
    logic                   ram_ce;
    logic                   ram_we;
    logic [BYTES-1:0]       ram_be;
    logic [DW-1:0]          ram_d;
    logic [DW-1:0]          ram_q = '0;

    ram_2p_rr_arbiter #(.NREQ(NREQ), .BYTES(BYTES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .ram_address_o(ram_address), .ram_ce_o(ram_ce), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_d_o(ram_d), .ram_q_i(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port behaviour: registered read data, byte-masked writes.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ce && !ram_we) ram_q <= ram_mem[ram_address];
        if (ram_ce && ram_we)
            for (int b = 0; b < int'(BYTES); b++)
                if (ram_be[b]) ram_mem[ram_address][b*8 +: 8] <= ram_d[b*8 +: 8];
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [DW-1:0]    ref_mem [DEPTH];
    int               m_ptr;
    bit               m_pend;
    int               m_id;
    logic [DW-1:0]    m_data;
    int               e_win;
    logic [NREQ-1:0]  e_ready, e_rsp_valid;
    logic [DW-1:0]    e_rdata, e_d;
    logic             e_ce, e_we;
    logic [AW-1:0]    e_addr;
    logic [BYTES-1:0] e_be;

    task automatic model_expect();
        if (!rst_n) begin m_ptr = 0; m_pend = 0; end
        e_win = -1;
        if (rst_n)
            for (int k = 0; k < int'(NREQ); k++) begin
                int idx;
                idx = (m_ptr + k) % int'(NREQ);
                if (e_win < 0 && req_valid[idx]) e_win = idx;
            end
        e_ready = '0; e_ce = 0; e_we = 0; e_addr = '0; e_be = '0; e_d = '0;
        if (e_win >= 0) begin
            e_ready[e_win] = 1'b1;
            e_ce   = 1'b1;
            e_we   = req_we[e_win];
            e_addr = req_addr[e_win*AW +: AW];
            e_be   = req_be[e_win*BYTES +: BYTES];
            e_d    = req_wdata[e_win*DW +: DW];
        end
        e_rsp_valid = '0; e_rdata = '0;
        if (m_pend) begin e_rsp_valid[m_id] = 1'b1; e_rdata = m_data; end
    endtask

    task automatic model_advance();
        logic [AW-1:0] a;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_pend = 0;
        end else begin
            m_pend = 0;
            if (e_win >= 0) begin
                a = req_addr[e_win*AW +: AW];
                m_ptr = (e_win + 1) % int'(NREQ);
                if (req_we[e_win]) begin
                    for (int b = 0; b < int'(BYTES); b++)
                        if (req_be[e_win*BYTES + b]) ref_mem[a][b*8 +: 8] = req_wdata[e_win*DW + b*8 +: 8];
                    if (WRACK) begin m_pend = 1; m_id = e_win; m_data = '0; end
                end else begin
                    m_pend = 1; m_id = e_win; m_data = ref_mem[a];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0;
        model_expect(); model_advance();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a,
                           input logic [BYTES-1:0] be, input logic [DW-1:0] d);
        req_we[i] = we; req_addr[i*AW +: AW] = a; req_be[i*BYTES +: BYTES] = be; req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1;
        for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, AW'(i), '1, '0);
        for (int c = 0; c < 2; c++) begin
            model_expect(); #1;
            n_checks++;
            if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
            n_checks++;
            if (ram_ce !== 1'b0) $display("FAIL reset_ce: got %b want 0", ram_ce); else n_pass++;
            n_checks++;
            if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp: got %b want 0000", rsp_valid); else n_pass++;
            model_advance();
        end
        rst_n = 1'b1;
        model_expect(); #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", req_ready); else n_pass++;
        model_advance();
        req_valid = '0;
        model_expect(); #1;
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'h0)
            $display("FAIL reset_first_rsp: got %b/%h want 0001/00000000", rsp_valid, rsp_rdata); else n_pass++;
        model_advance();
    endtask

    task automatic test_write_read();
        req_valid = 4'b0010;
        set_req(1, 1'b1, 8'h10, 4'b0101, 32'hDEADBEEF);
        model_expect(); #1;
        n_checks++;
        if ({req_ready, ram_ce, ram_we, ram_address, ram_be, ram_d} !== {4'b0010, 1'b1, 1'b1, 8'h10, 4'b0101, 32'hDEADBEEF})
            $display("FAIL wr_port: got %b %b %b %h %b %h", req_ready, ram_ce, ram_we, ram_address, ram_be, ram_d); else n_pass++;
        model_advance();
        req_valid = 4'b0100;
        set_req(2, 1'b0, 8'h10, 4'b0000, 32'h0);
        model_expect(); #1;
        n_checks++;
        if (req_ready !== 4'b0100 || ram_we !== 1'b0) $display("FAIL rd_grant: got %b we=%b want 0100 we=0", req_ready, ram_we); else n_pass++;
        n_checks++;
        if (rsp_valid !== (WRACK ? 4'b0010 : 4'b0000)) $display("FAIL wr_rsp: got %b want %b", rsp_valid, WRACK ? 4'b0010 : 4'b0000); else n_pass++;
        model_advance();
        req_valid = '0;
        model_expect(); #1;
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'h00AD00EF)
            $display("FAIL rd_after_wr: got %b/%h want 0100/00ad00ef", rsp_valid, rsp_rdata); else n_pass++;
        model_advance();
    endtask

    task automatic test_round_robin();
        int g [5] = '{0, 1, 2, 3, 0};
        do_reset();
        req_valid = '1;
        for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, AW'(8'h0E + i), '0, '0);
        for (int c = 0; c < 6; c++) begin
            if (c == 5) req_valid = '0;
            model_expect(); #1;
            if (c < 5) begin
                n_checks++;
                if (req_ready !== (4'b0001 << g[c])) $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, 4'b0001 << g[c]); else n_pass++;
            end
            n_checks++;
            if (rsp_valid !== ((c == 0) ? 4'b0000 : (4'b0001 << g[c-1])) || rsp_rdata !== e_rdata)
                $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", c, rsp_valid, rsp_rdata,
                         (c == 0) ? 4'b0000 : (4'b0001 << g[c-1]), e_rdata); else n_pass++;
            model_advance();
        end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        req_valid = 4'b0001; set_req(0, 1'b0, 8'h01, '0, '0);
        model_expect(); model_advance();
        req_valid = 4'b1000; set_req(3, 1'b0, 8'h02, '0, '0);
        model_expect(); #1;
        n_checks++;
        if (req_ready !== 4'b1000) $display("FAIL ptr_only3: got %b want 1000", req_ready); else n_pass++;
        model_advance();
        req_valid = 4'b1001;
        model_expect(); #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL ptr_wrap0: got %b want 0001", req_ready); else n_pass++;
        model_advance();
        req_valid = '0;
        model_expect(); model_advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0100; set_req(2, 1'b0, 8'h10, '0, '0);
        model_expect(); model_advance();
        rst_n = 1'b0; req_valid = '0;
        model_expect(); #1;
        n_checks++;
        if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'h0) $display("FAIL mid_reset_rsp: got %b/%h want 0000/0", rsp_valid, rsp_rdata); else n_pass++;
        model_advance();
        rst_n = 1'b1; req_valid = 4'b0101;
        set_req(0, 1'b0, 8'h03, '0, '0);
        model_expect(); #1;
        n_checks++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001)
            $display("FAIL mid_reset_release: got rsp=%b rdy=%b want 0000/0001", rsp_valid, req_ready); else n_pass++;
        model_advance();
        req_valid = 4'b0100;
        model_expect(); model_advance();
        req_valid = '0;
        model_expect(); model_advance();
    endtask

    task automatic test_wrack();
        req_valid = 4'b0100; set_req(2, 1'b1, 8'h20, 4'b1111, 32'h12345678);
        model_expect(); model_advance();
        req_valid = '0;
        model_expect(); #1;
        n_checks++;
        if (rsp_valid !== (WRACK ? 4'b0100 : 4'b0000) || rsp_rdata !== 32'h0)
            $display("FAIL wrack: got %b/%h want %b/0", rsp_valid, rsp_rdata, WRACK ? 4'b0100 : 4'b0000); else n_pass++;
        model_advance();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] last_ready;
        do_reset();
        last_ready = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(NREQ); i++)
                if (!req_valid[i] || last_ready[i]) begin
                    req_valid[i] = ($urandom % 4) != 0;
                    set_req(i, 1'($urandom % 2), AW'($urandom_range(0, 31)), BYTES'($urandom), $urandom);
                end
            model_expect(); #1;
            n_checks++;
            if ({req_ready, ram_ce, ram_we, ram_address, ram_be, ram_d} !== {e_ready, e_ce, e_we, e_addr, e_be, e_d})
                $display("FAIL rand_port%0d: got %b %b %b %h %b %h want %b %b %b %h %b %h", c,
                         req_ready, ram_ce, ram_we, ram_address, ram_be, ram_d, e_ready, e_ce, e_we, e_addr, e_be, e_d);
            else n_pass++;
            n_checks++;
            if (rsp_valid !== e_rsp_valid || rsp_rdata !== e_rdata)
                $display("FAIL rand_rsp%0d: got %b/%h want %b/%h", c, rsp_valid, rsp_rdata, e_rsp_valid, e_rdata);
            else n_pass++;
            last_ready = e_ready;
            model_advance();
        end
        req_valid = '0;
        model_expect(); model_advance();
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin ram_mem[i] = '0; ref_mem[i] = '0; end
        m_ptr = 0; m_pend = 0; m_id = 0; m_data = '0;
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_be = '0; req_wdata = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_round_robin();
        test_ptr_wrap();
        test_reset_mid();
        test_wrack();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
